// File: rtl/pair_accum_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pair_accum_pkg                                            |
// | Purpose  : Shared types and helpers for the pair window accumulator. |
// |            State encoding, the pair weight function and the minimum  |
// |            legal width of the window total.                          |
// | Ports    : none (package)                                            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package pair_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Arithmetic weight of a pair is sum + 2*carry, which is exactly the
  // two-bit vector {carry, sum}.
  function automatic logic [1:0] w(input logic sum, input logic carry);
    return {carry, sum};
  endfunction

  // Smallest total width that holds 3*window without overflow.
  function automatic int min_cnt_w(input int window);
    return $clog2(3 * window + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pair_weight.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pair_weight                                               |
// | Purpose  : Combinational map of a (sum, carry) pair to its weight    |
// |            and an illegal-pair flag (both bits set together).        |
// | Ports    : sum_i, carry_i    - pair bits from the half-adder stage   |
// |            weight_o [1:0]    - sum + 2*carry                         |
// |            illegal_o         - sum and carry both high               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module pair_weight
  import pair_accum_pkg::*;
(
  input  logic       sum_i,
  input  logic       carry_i,
  output logic [1:0] weight_o,
  output logic       illegal_o
);

  assign weight_o  = w(sum_i, carry_i);
  assign illegal_o = sum_i & carry_i;

endmodule
`default_nettype wire

// File: rtl/pair_window_accum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pair_window_accum                                         |
// | Purpose  : Accumulates pair weights over WINDOW accepted samples and |
// |            presents the total on a valid/ready handshake. Flags      |
// |            illegal (1,1) pairs with a sticky error bit.              |
// | Ports    : clk, rst          - clock, synchronous active-high reset  |
// |            start             - open a new window (IDLE / DONE)       |
// |            in_valid, in_sum, in_carry - upstream pair                |
// |            busy              - window in progress                    |
// |            out_valid, out_ready, out_count - result handshake        |
// |            err               - sticky illegal-pair flag              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module pair_window_accum
  import pair_accum_pkg::*;
#(
  parameter int WINDOW = 8,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_sum,
  input  logic             in_carry,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             err
);

  localparam int SAMP_W = $clog2(WINDOW + 1);
  localparam logic [SAMP_W-1:0] LAST_IDX = SAMP_W'(WINDOW - 1);

  generate
    if (WINDOW < 1 || WINDOW > 255) begin : g_bad_window
      $error("pair_window_accum: WINDOW out of range 1..255");
    end
    if (CNT_W < min_cnt_w(WINDOW)) begin : g_bad_cnt_w
      $error("pair_window_accum: CNT_W too narrow for 3*WINDOW");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [SAMP_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic              err_q, err_d;

  logic [1:0]        weight;
  logic              illegal;
  logic [CNT_W-1:0]  acc_sum;

  pair_weight u_weight (
    .sum_i     (in_sum),
    .carry_i   (in_carry),
    .weight_o  (weight),
    .illegal_o (illegal)
  );

  assign acc_sum = acc_q + CNT_W'(weight);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_count_q <= out_count_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_count_d = out_count_q;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
          if (illegal) begin
            err_d = 1'b1;
          end
          // The final sample goes straight into the registered result so
          // out_count is valid in the same cycle out_valid rises.
          if (cnt_q == LAST_IDX) begin
            state_d     = DONE;
            out_count_d = acc_sum;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          if (start) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_count = out_count_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: doc/pair_window_accum.md
Name: pair_window_accum

Overview:
- Downstream consumer of the registered half-adder pair stage, which outputs one sum bit (XOR) and one carry bit (AND) per clock.
- Accumulates the arithmetic weight of each accepted pair (sum + 2*carry) over a fixed window of WINDOW samples.
- Presents the window total on a valid/ready output handshake.
- Flags illegal pairs (sum=1 and carry=1 together), which the upstream stage can never produce legitimately.

Parameters:
- WINDOW, 8, number of accepted sample pairs per window; legal range 1..255.
- CNT_W, 5, width of out_count; must satisfy 2^CNT_W > 3*WINDOW (checked by elaboration-time assertion).

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request to open a new window; sampled in IDLE, and in DONE when the handshake completes.
- in_valid  input  1  upstream pair valid this cycle.
- in_sum  input  1  sum bit from upstream stage.
- in_carry  input  1  carry bit from upstream stage.
- busy  output  1  high in ACCUM.
- out_valid  output  1  window result available (DONE state).
- out_ready  input  1  downstream accepts result.
- out_count  output  CNT_W  window total.
- err  output  1  sticky illegal-pair flag.

Behaviour:
- Reset: clk and rst as above; rst is synchronous and active-high. While rst=1 at a clock edge:
  - state <= IDLE; accumulator <= 0; sample counter <= 0.
  - out_valid=0, out_count=0, busy=0, err=0.
  - rst dominates every other input, including mid-window and mid-handshake; any partial sum is discarded.
- FSM states IDLE, ACCUM, DONE:
  - IDLE: start=1 -> ACCUM; clear accumulator and sample counter. in_valid is ignored in IDLE.
  - ACCUM:
    - Each cycle with in_valid=1, add w = in_sum + 2*in_carry (0..3) to the accumulator and increment the sample counter.
    - When the accepted sample is number WINDOW, go to DONE next cycle. That final sample is included in the total.
    - start is ignored in ACCUM.
  - DONE:
    - out_valid=1; out_count holds the final total, stable until the handshake completes.
    - out_valid && out_ready -> handshake completes. Next state is ACCUM if start=1 that same cycle (accumulator cleared), otherwise IDLE.
    - in_valid is ignored in DONE; samples presented there are dropped, not buffered.
- Latency: the result is visible on out_valid the cycle after the WINDOW-th sample is accepted. With WINDOW=1 this means ACCUM lasts until one sample, then DONE.
- out_count is registered. It is 0 in IDLE and ACCUM until the first DONE; from then on it holds the last total until a new window reaches DONE.
- Illegal pair: in ACCUM, in_valid=1 with in_sum=1 and in_carry=1 sets err=1 the next cycle.
  - The weight 3 is still accumulated, so width is sized for 3*WINDOW.
  - err is cleared only by rst.
- Width: the accumulator is CNT_W bits and cannot overflow given the CNT_W constraint. The sample counter is clog2(WINDOW+1) bits.
- in_valid gaps: no samples are accepted while in_valid=0; the window stretches, with no timeout.

Decomposition:
- Shared package pair_accum_pkg holds:
  - state enum (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2);
  - weight function w(sum, carry);
  - helper for the CNT_W minimum.
- One natural sub-module: pair_weight. It is combinational: it maps (sum, carry) to a 2-bit weight plus an illegal flag. It is reused by the top FSM/datapath.

Test Plan:
- Reset mid-window:
  - Stimulus: start, accept 3 pairs (1,0), assert rst for 1 cycle.
  - Required response: state IDLE, out_valid=0, out_count=0, err=0; a new window then totals from 0.
- Nominal window, WINDOW=8:
  - Stimulus: start, 8 contiguous valid pairs alternating (1,0),(0,1).
  - Required response: out_valid rises the cycle after the 8th pair, out_count=12, busy low in DONE.
- Gapped input:
  - Stimulus: 8 pairs (0,1) interleaved with in_valid=0 gaps of 1-3 cycles.
  - Required response: out_count=16; zero-valid cycles add nothing.
- Back-pressure and back-to-back windows:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1.
  - Required response: out_count stable at 12, no samples counted.
  - Then: out_ready=1 with start=1.
  - Required response: direct DONE->ACCUM; the next window is counted from 0.
- Illegal pair:
  - Stimulus: one pair (1,1) among 7 pairs (1,0).
  - Required response: err=1 next cycle and sticky; out_count=10.
  - Then: rst.
  - Required response: err=0.
- Ignore rules:
  - Stimulus: in_valid=1 with start=0 in IDLE.
  - Required response: no state change.
  - Stimulus: start pulsed during ACCUM.
  - Required response: window not restarted; total unaffected.
